uart_rx: RTL and testbench

UART receiver that sits next to `franken_riscv` on the `RXD` line, the receive counterpart of the core's `TXD` transmitter. It deserialises 8N1 frames from the asynchronous `rxd` pin, buffers completed bytes in a small first-word-fall-through FIFO, and presents them to the CPU as a read-pop interface with sticky framing and overrun flags. It runs on the system clock `clk`, not the 1 Hz CPU clock, so any CPU-side strobe must already be a single-`clk`-cycle pulse.

---
 rtl/uart_pkg.sv | 13 +
 rtl/rx_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path and the future uart_tx.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;
endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive buffer with extra-MSB pointers.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, frame FSM, FIFO and sticky error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state, state_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [IW-1:0]             idx, idx_n;
    logic [UART_DATA_BITS-1:0] data, data_n;
    logic                      sync1, rxd_s;
    logic                      push, frame_set, full, empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            data  <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        idx_n     = idx;
        data_n    = data;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_n       = '0;
                    data_n[idx] = rxd_s;
                    idx_n       = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_n     = '0;
                    push      = rxd_s;
                    frame_set = !rxd_s;
                    state_n   = rxd_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(UART_DATA_BITS)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  (data),
        .full (full),
        .pop  (rd_en),
        .dout (rd_data),
        .empty(empty)
    );

    assign rx_valid = !empty;

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (push && full && !(rd_en && rx_valid)) overrun <= 1'b1;
            else if (err_clr)                         overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a byte-queue model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       ovr_m = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; optionally pulse rd_en on cycle pop_at, or stop early.
    task automatic send(input logic [7:0] b, input logic stopb,
                        input int pop_at, input int abort_at);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == abort_at) begin
                rd_en = 1'b0;
                return;
            end
            rxd   = f[c / CPB];
            rd_en = (c == pop_at);
            step();
        end
        rd_en = 1'b0;
        rxd   = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else ovr_m = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send(b, 1'b1, -1, -1);
        model_frame(b);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, rx_valid, 1'b1);
        if (q.size() != 0) begin
            check({tag, "_data"}, rd_data, q[0]);
            void'(q.pop_front());
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, rx_valid, q.size() != 0);
        if (q.size() != 0) check({tag, "_head"}, rd_data, q[0]);
        check({tag, "_ovr"}, overrun, ovr_m);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        ovr_m   = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        reset   = 1'b1;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        step();
        step();
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        reset = 1'b0;
        step();

        // Two back-to-back frames
        send_good(8'h55);
        send_good(8'hA3);
        step();
        check_model("b2b");
        pop_check("b2b_0");
        pop_check("b2b_1");
        check("b2b_empty", rx_valid, 1'b0);
        check("b2b_ferr", frame_err, 1'b0);
        check("b2b_ovr", overrun, 1'b0);

        // Short glitch on idle line
        rxd = 1'b0;
        repeat (3) step();
        rxd = 1'b1;
        repeat (3 * CPB) step();
        check("glitch_state", dut.state, IDLE);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr", frame_err, 1'b0);
        check("glitch_ovr", overrun, 1'b0);

        // Framing error followed by a long break
        send(8'h3C, 1'b0, -1, -1);
        rxd = 1'b0;
        repeat (20 * CPB) step();
        check("ferr_set", frame_err, 1'b1);
        check("ferr_nopush", rx_valid, 1'b0);
        check("ferr_wait", dut.state, WAIT_HIGH);
        rxd = 1'b1;
        repeat (4) step();
        send_good(8'h11);
        step();
        pop_check("ferr_next");
        check("ferr_sticky", frame_err, 1'b1);
        clear_flags();
        check("ferr_clr", frame_err, 1'b0);

        // Overrun with no reads
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        step();
        check("ovr_set", overrun, 1'b1);
        check_model("ovr");
        for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
        check("ovr_empty", rx_valid, 1'b0);
        clear_flags();
        check("ovr_clr", overrun, 1'b0);

        // Pop on the push cycle of a frame into a full FIFO
        for (int i = 1; i <= 4; i++) send_good(8'(i));
        send(8'h77, 1'b1, 10 * CPB - 2, -1);
        void'(q.pop_front());
        q.push_back(8'h77);
        step();
        check("simul_ovr", overrun, 1'b0);
        check_model("simul");
        while (q.size() != 0) pop_check("simul_pop");
        check("simul_empty", rx_valid, 1'b0);

        // Reset during data bit 4 with two bytes buffered
        send_good(8'($urandom));
        send_good(8'($urandom));
        send(8'h5A, 1'b1, -1, 5 * CPB + 4);
        reset = 1'b1;
        rxd   = 1'b1;
        q.delete();
        ovr_m = 1'b0;
        step();
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_data", rd_data, 8'h00);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        step();
        reset = 1'b0;
        step();
        send_good(8'h9E);
        step();
        check_model("post_rst");
        pop_check("post_rst");

        // Randomized traffic with occasional reads
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            send_good(b);
            check_model("rnd");
            if ($urandom_range(0, 2) == 0 && q.size() != 0) pop_check("rnd_pop");
        end
        while (q.size() != 0) pop_check("rnd_drain");
        check("rnd_empty", rx_valid, 1'b0);
        check("rnd_ovr", overrun, ovr_m);
        check("rnd_ferr", frame_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
